key_event_gen: RTL and testbench



---
 rtl/key_event_gen_if.sv | 35 +++
 rtl/key_event_gen.sv | 140 ++++++++++++++
 tb/tb_key_event_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen_if
// Description : Key level inputs and per-key event outputs of key_event_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_gen_if #(
    parameter int W = 1
);
    logic [W-1:0] i_key_in;
    logic [W-1:0] o_press;
    logic [W-1:0] o_release;
    logic [W-1:0] o_long_press;
    logic [W-1:0] o_repeat;
    logic [W-1:0] o_held;

    modport master (
        output i_key_in,
        input  o_press,
        input  o_release,
        input  o_long_press,
        input  o_repeat,
        input  o_held
    );

    modport slave (
        input  i_key_in,
        output o_press,
        output o_release,
        output o_long_press,
        output o_repeat,
        output o_held
    );
endinterface
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen
// Description : Per-key press / release / long-press / auto-repeat pulse
//               generator. Auto-repeat enabled by KEY_EVENT_GEN_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_gen #(
    parameter int W             = 1,
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = 26,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    key_event_gen_if.slave    bus
);

    localparam logic [1:0]       c_IDLE      = 2'd0;
    localparam logic [1:0]       c_HOLD      = 2'd1;
    localparam logic [1:0]       c_LONG      = 2'd2;
    localparam logic             c_UP_LEVEL  = 1'(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [W-1:0] w_press;
    logic [W-1:0] w_release;
    logic [W-1:0] w_long_press;
    logic [W-1:0] w_repeat;
    logic [W-1:0] w_held;

    for (genvar gi = 0; gi < W; gi++) begin : g_key
        logic             w_down;
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_press,      w_press_nxt;
        logic             r_release,    w_release_nxt;
        logic             r_long_press, w_long_press_nxt;
        logic             r_repeat,     w_repeat_nxt;
        logic             r_held,       w_held_nxt;

        assign w_down = bus.i_key_in[gi] ^ c_UP_LEVEL;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state      <= c_IDLE;
                r_cnt        <= '0;
                r_press      <= 1'b0;
                r_release    <= 1'b0;
                r_long_press <= 1'b0;
                r_repeat     <= 1'b0;
                r_held       <= 1'b0;
            end else begin
                r_state      <= w_state_nxt;
                r_cnt        <= w_cnt_nxt;
                r_press      <= w_press_nxt;
                r_release    <= w_release_nxt;
                r_long_press <= w_long_press_nxt;
                r_repeat     <= w_repeat_nxt;
                r_held       <= w_held_nxt;
            end
        end

        // Release always wins over a terminal count in the same cycle.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                c_IDLE: begin
                    if (w_down) begin
                        w_state_nxt = c_HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                c_HOLD: begin
                    if (!w_down) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt = c_LONG;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                c_LONG: begin
                    if (!w_down) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                    end else if (r_cnt == c_REP_LAST) begin
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
`else
                    end else begin
                        w_cnt_nxt   = '0;
                    end
`endif
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            w_press_nxt      = (r_state == c_IDLE) && w_down;
            w_release_nxt    = (r_state != c_IDLE) && !w_down;
            w_long_press_nxt = (r_state == c_HOLD) && w_down && (r_cnt == c_HOLD_LAST);
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
            w_repeat_nxt     = (r_state == c_LONG) && w_down && (r_cnt == c_REP_LAST);
`else
            w_repeat_nxt     = 1'b0;
`endif
            w_held_nxt       = (w_state_nxt != c_IDLE);
        end

        assign w_press[gi]      = r_press;
        assign w_release[gi]    = r_release;
        assign w_long_press[gi] = r_long_press;
        assign w_repeat[gi]     = r_repeat;
        assign w_held[gi]       = r_held;
    end

    assign bus.o_press      = w_press;
    assign bus.o_release    = w_release;
    assign bus.o_long_press = w_long_press;
    assign bus.o_repeat     = w_repeat;
    assign bus.o_held       = w_held;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_gen
// Description : Directed self-checking bench for key_event_gen (2 keys,
//               active-low, hold 4, repeat 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;

    localparam int c_HOLD = 4;
    localparam int c_REP  = 3;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
    localparam bit c_REP_EN = 1'b1;
`else
    localparam bit c_REP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    key_event_gen_if #(.W(2)) kif ();

    key_event_gen #(
        .W             (2),
        .ACTIVE_LOW    (1),
        .CNT_W         (8),
        .HOLD_CYCLES   (c_HOLD),
        .REPEAT_CYCLES (c_REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {press, release, long_press, repeat, held} of a key whose
    // down level was first sampled d edges ago; rel = up sampled this edge.
    function automatic logic [4:0] key_exp(int d, bit rel);
        logic [4:0] e;
        e = 5'b00000;
        if (rel) begin
            e = 5'b01000;
        end else if (d >= 0) begin
            e[4] = (d == 0);
            e[2] = (d == c_HOLD);
            e[1] = c_REP_EN && (d > c_HOLD) && (((d - c_HOLD) % c_REP) == 0);
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(string tag, logic [4:0] e1, logic [4:0] e0);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {kif.o_press[1], kif.o_release[1], kif.o_long_press[1], kif.o_repeat[1], kif.o_held[1],
               kif.o_press[0], kif.o_release[0], kif.o_long_press[0], kif.o_repeat[0], kif.o_held[0]};
        exp = {e1, e0};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed k1/k0 {pr,rl,lp,rp,hd}=%b_%b expected=%b_%b",
                   tag, obs[9:5], obs[4:0], exp[9:5], exp[4:0]);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        kif.i_key_in = 2'b11;

        tick();
        check("reset_high_a", 5'b0, 5'b0);
        tick();
        check("reset_high_b", 5'b0, 5'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_keys_up", 5'b0, 5'b0);
        end

        // Two-cycle press on key 0.
        kif.i_key_in = 2'b10;
        tick();
        check("short_press", 5'b0, 5'b10001);
        tick();
        check("short_held", 5'b0, 5'b00001);
        kif.i_key_in = 2'b11;
        tick();
        check("short_release", 5'b0, 5'b01000);
        tick();
        check("short_quiet", 5'b0, 5'b0);

        // Twelve-cycle hold on key 0.
        kif.i_key_in = 2'b10;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("long_hold_%0d", k), 5'b0, key_exp(k, 1'b0));
        end
        kif.i_key_in = 2'b11;
        tick();
        check("long_release", 5'b0, 5'b01000);
        tick();
        check("long_quiet", 5'b0, 5'b0);

        // Release sampled on the edge where long_press would fire.
        kif.i_key_in = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("prio_hold_%0d", k), 5'b0, key_exp(k, 1'b0));
        end
        kif.i_key_in = 2'b11;
        tick();
        check("prio_release_only", 5'b0, 5'b01000);
        tick();
        check("prio_quiet", 5'b0, 5'b0);

        // Key 1 pressed one cycle after key 0, both released together.
        for (int t = 0; t <= 10; t++) begin
            kif.i_key_in[0] = (t < 10) ? 1'b0 : 1'b1;
            kif.i_key_in[1] = (t >= 1 && t < 10) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("two_keys_%0d", t), key_exp(t - 1, t == 10), key_exp(t, t == 10));
        end
        tick();
        check("two_keys_quiet", 5'b0, 5'b0);

        // Reset in LONG, key still down.
        kif.i_key_in = 2'b10;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rst_hold_%0d", k), 5'b0, key_exp(k, 1'b0));
        end
        reset = 1'b1;
        #1;
        check("rst_async_clear", 5'b0, 5'b0);
        tick();
        check("rst_no_release", 5'b0, 5'b0);
        reset = 1'b0;
        tick();
        check("rst_repress", 5'b0, 5'b10001);
        kif.i_key_in = 2'b11;
        tick();
        check("rst_release", 5'b0, 5'b01000);
        tick();
        check("rst_quiet", 5'b0, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
